// File: rtl/clock_core_pkg.sv
// clock_core_pkg: shared BCD limits, widths and ring FSM encoding for the clock datapath
package clock_core_pkg;
  localparam int BCD_W = 16;
  localparam int SEC_W = 6;
  localparam logic [3:0] H1_MAX = 4'd2;
  localparam logic [3:0] H0_MAX = 4'd9;
  localparam logic [3:0] H0_MAX_H2 = 4'd3;
  localparam logic [3:0] M1_MAX = 4'd5;
  localparam logic [3:0] M0_MAX = 4'd9;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  typedef enum logic {S_IDLE = 1'b0, S_RING = 1'b1} ring_state_t;
endpackage

// File: rtl/clock_core_bcd_hhmm_check.sv
// bcd_hhmm_check: flags whether a 16-bit BCD HHMM word is a legal 24-hour time
module bcd_hhmm_check
  import clock_core_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic             valid
);
  assign valid = d[15:12] <= H1_MAX
              && d[11:8] <= (d[15:12] == H1_MAX ? H0_MAX_H2 : H0_MAX)
              && d[7:4] <= M1_MAX
              && d[3:0] <= M0_MAX;
endmodule

// File: rtl/clock_core.sv
// clock_core: BCD time-of-day counter with alarm register, ring FSM and display mux
module clock_core
  import clock_core_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int RING_SECS = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_clk,
  input  logic             clock_load,
  input  logic             ring_load,
  input  logic [BCD_W-1:0] data_in,
  input  logic             mode_clk,
  input  logic             mode_ring,
  input  logic             mode_clk_ad,
  input  logic             mode_ring_ad,
  input  logic             ring_stop,
  output logic [BCD_W-1:0] time_out,
  output logic [SEC_W-1:0] sec_out,
  output logic [BCD_W-1:0] disp_data,
  output logic             ring_out,
  output logic             load_err
);
  localparam int PW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [5:0] RING_LAST = 6'(RING_SECS - 1);
  logic [PW-1:0] presc;
  logic [BCD_W-1:0] alarm, nxt_time;
  logic armed, clk_ok, ring_ok, sec_tick, do_clk, do_ring, adv, trig;
  logic c_m, c_m1, c_h, unused_modes;
  logic [3:0] h1, h0, m1, m0;
  logic [5:0] ring_cnt;
  ring_state_t state;
  bcd_hhmm_check u_clk_chk (.d(data_in), .valid(clk_ok));
  bcd_hhmm_check u_ring_chk (.d(data_in), .valid(ring_ok));
  assign {h1, h0, m1, m0} = time_out;
  assign unused_modes = mode_clk | mode_clk_ad;
  assign disp_data = (mode_ring || mode_ring_ad) ? alarm : time_out;
  always_comb begin
    sec_tick = presc == PRESC_LAST;
    do_clk = clock_load && clk_ok;
    do_ring = ring_load && ring_ok;
    adv = sec_tick && en_clk && !do_clk;
    c_m = sec_out == SEC_MAX;
    c_m1 = c_m && m0 == M0_MAX;
    c_h = c_m1 && m1 == M1_MAX;
    nxt_time[3:0] = c_m ? (m0 == M0_MAX ? 4'd0 : m0 + 4'd1) : m0;
    nxt_time[7:4] = c_m1 ? (m1 == M1_MAX ? 4'd0 : m1 + 4'd1) : m1;
    nxt_time[15:8] = !c_h ? {h1, h0}
                   : (h1 == H1_MAX && h0 == H0_MAX_H2) ? 8'h00
                   : h0 == H0_MAX ? {h1 + 4'd1, 4'd0}
                   : {h1, h0 + 4'd1};
    // only a minute rollover into the alarm time rings; a load never does
    trig = adv && armed && c_m && nxt_time == alarm;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      time_out <= '0;
      sec_out <= '0;
      alarm <= '0;
      armed <= 1'b0;
      state <= S_IDLE;
      ring_cnt <= '0;
      ring_out <= 1'b0;
      load_err <= 1'b0;
    end else begin
      presc <= (do_clk || sec_tick) ? '0 : presc + 1'b1;
      load_err <= (clock_load && !clk_ok) || (ring_load && !ring_ok);
      if (do_clk) begin
        time_out <= data_in;
        sec_out <= '0;
      end else if (adv) begin
        time_out <= nxt_time;
        sec_out <= c_m ? '0 : sec_out + 6'd1;
      end
      if (do_ring) begin
        alarm <= data_in;
        armed <= 1'b1;
      end
      if (do_ring || (state == S_RING && (ring_stop || (sec_tick && ring_cnt == RING_LAST)))) begin
        state <= S_IDLE;
        ring_out <= 1'b0;
      end else if (state == S_IDLE && trig) begin
        state <= S_RING;
        ring_out <= 1'b1;
        ring_cnt <= '0;
      end else if (state == S_RING && sec_tick) begin
        ring_cnt <= ring_cnt + 6'd1;
      end
    end
  end
endmodule
